// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the 16-bit RISC datapath.
// The master side is the sequencer; the slave side is the datapath/memory.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      instr;
  logic             mem_ready;
  logic             zero;
  logic [1:0]       ALU_sel;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic             mem_rd;
  logic             mem_wr;
  logic             addr_sel;
  logic             reg_wr;
  logic             wb_sel;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    input  instr, mem_ready, zero,
    output ALU_sel, ir_load, pc_inc, pc_load, mem_rd, mem_wr,
           addr_sel, reg_wr, wb_sel, halted, retired, state
  );

  modport slave (
    output instr, mem_ready, zero,
    input  ALU_sel, ir_load, pc_inc, pc_load, mem_rd, mem_wr,
           addr_sel, reg_wr, wb_sel, halted, retired, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, strobe decode
// and a wrapping retired-instruction counter. Only state and retired are stored.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_RALU  = 3'b000;
  localparam logic [2:0] OP_IALU  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_BEQZ  = 3'b100;
  localparam logic [2:0] OP_JUMP  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_RFN  = 2'b01;
  localparam logic [1:0] ALU_IFN  = 2'b10;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;
  logic [2:0]       opcode;

  logic [1:0] alu_sel_next;
  logic       ir_load_next, pc_inc_next, pc_load_next;
  logic       mem_rd_next, mem_wr_next, addr_sel_next;
  logic       reg_wr_next, wb_sel_next, halted_next;

  assign opcode = bus.instr[15:13];

  // Function fields are decoded by the ALU decoder, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[12:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        retired_reg <= retired_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    retire        = 1'b0;
    alu_sel_next  = ALU_ADD;
    ir_load_next  = 1'b0;
    pc_inc_next   = 1'b0;
    pc_load_next  = 1'b0;
    mem_rd_next   = 1'b0;
    mem_wr_next   = 1'b0;
    addr_sel_next = 1'b0;
    reg_wr_next   = 1'b0;
    wb_sel_next   = 1'b0;
    halted_next   = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        mem_rd_next = 1'b1;
        if (bus.mem_ready) begin
          ir_load_next = 1'b1;
          pc_inc_next  = 1'b1;
          state_next   = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_JUMP: begin
            pc_load_next = 1'b1;
            retire       = 1'b1;
            state_next   = S_FETCH;
          end
          OP_NOP: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_HALT: state_next = S_HALT;
          default: state_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_RALU: begin
            alu_sel_next = ALU_RFN;
            state_next   = S_WB;
          end
          OP_IALU: begin
            alu_sel_next = ALU_IFN;
            state_next   = S_WB;
          end
          OP_LOAD, OP_STORE: state_next = S_MEM;
          OP_BEQZ: begin
            pc_load_next = bus.zero;
            retire       = 1'b1;
            state_next   = S_FETCH;
          end
          // Only reachable if instr changes under us; abandon without retiring.
          default: state_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        addr_sel_next = 1'b1;
        mem_rd_next   = (opcode == OP_LOAD);
        mem_wr_next   = (opcode == OP_STORE);
        if (opcode != OP_LOAD && opcode != OP_STORE) begin
          state_next = S_FETCH;
        end else if (bus.mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_next = S_WB;
          end else begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
      end

      S_WB: begin
        // Hold the EXEC select so the written-back result stays stable.
        case (opcode)
          OP_RALU: alu_sel_next = ALU_RFN;
          OP_IALU: alu_sel_next = ALU_IFN;
          default: alu_sel_next = ALU_ADD;
        endcase
        reg_wr_next = 1'b1;
        wb_sel_next = (opcode == OP_LOAD);
        retire      = 1'b1;
        state_next  = S_FETCH;
      end

      S_HALT: halted_next = 1'b1;

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.ALU_sel  = alu_sel_next;
  assign bus.ir_load  = ir_load_next;
  assign bus.pc_inc   = pc_inc_next;
  assign bus.pc_load  = pc_load_next;
  assign bus.mem_rd   = mem_rd_next;
  assign bus.mem_wr   = mem_wr_next;
  assign bus.addr_sel = addr_sel_next;
  assign bus.reg_wr   = reg_wr_next;
  assign bus.wb_sel   = wb_sel_next;
  assign bus.halted   = halted_next;
  assign bus.retired  = retired_reg;
  assign bus.state    = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table for the
// instruction mix, then hand sequences for HALT, async reset and counter wrap.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ctrl bits: ir_load pc_inc pc_load mem_rd mem_wr addr_sel reg_wr wb_sel halted
  typedef struct {
    logic [15:0]      instr;
    logic             mem_ready;
    logic             zero;
    logic [2:0]       exp_state;
    logic [1:0]       exp_alu;
    logic [8:0]       exp_ctrl;
    logic [CNT_W-1:0] exp_retired;
  } vec_t;

  localparam int NVEC = 37;
  vec_t tbl [NVEC];

  function automatic logic [8:0] ctrl_now();
    return {bus.ir_load, bus.pc_inc, bus.pc_load, bus.mem_rd, bus.mem_wr,
            bus.addr_sel, bus.reg_wr, bus.wb_sel, bus.halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic mr, input logic z);
    bus.instr = i;
    bus.mem_ready = mr;
    bus.zero = z;
    #1;
    chk("rd_wr_excl", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
    chk("inc_load_excl", {31'd0, bus.pc_inc & bus.pc_load}, 32'd0);
  endtask

  task automatic cycle(input logic [15:0] i, input logic mr, input logic z);
    @(negedge clk);
    drive(i, mr, z);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] alu,
                         input logic [8:0] ctrl, input logic [CNT_W-1:0] ret);
    chk({tag, "_state"}, {29'd0, bus.state}, {29'd0, st});
    chk({tag, "_alu"}, {30'd0, bus.ALU_sel}, {30'd0, alu});
    chk({tag, "_ctrl"}, {23'd0, ctrl_now()}, {23'd0, ctrl});
    chk({tag, "_retired"}, {{(32-CNT_W){1'b0}}, bus.retired}, {{(32-CNT_W){1'b0}}, ret});
    $display("cyc st=%0d alu=%0d ctrl=%b ret=%0d", bus.state, bus.ALU_sel, ctrl_now(), bus.retired);
  endtask

  initial begin
    // instr mr z state alu ctrl retired
    tbl[0]  = '{16'h0200, 1'b1, 1'b0, 3'd0, 2'b00, 9'b000000000, 8'd0}; // IDLE
    tbl[1]  = '{16'h0200, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd0}; // R-ALU
    tbl[2]  = '{16'h0200, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd0};
    tbl[3]  = '{16'h0200, 1'b1, 1'b0, 3'd3, 2'b01, 9'b000000000, 8'd0};
    tbl[4]  = '{16'h0200, 1'b1, 1'b0, 3'd5, 2'b01, 9'b000000100, 8'd0};
    tbl[5]  = '{16'h2005, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd1}; // I-ALU
    tbl[6]  = '{16'h2005, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd1};
    tbl[7]  = '{16'h2005, 1'b1, 1'b0, 3'd3, 2'b10, 9'b000000000, 8'd1};
    tbl[8]  = '{16'h2005, 1'b1, 1'b0, 3'd5, 2'b10, 9'b000000100, 8'd1};
    tbl[9]  = '{16'h4000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd2}; // LOAD
    tbl[10] = '{16'h4000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd2};
    tbl[11] = '{16'h4000, 1'b1, 1'b0, 3'd3, 2'b00, 9'b000000000, 8'd2};
    tbl[12] = '{16'h4000, 1'b0, 1'b0, 3'd4, 2'b00, 9'b000101000, 8'd2};
    tbl[13] = '{16'h4000, 1'b0, 1'b0, 3'd4, 2'b00, 9'b000101000, 8'd2};
    tbl[14] = '{16'h4000, 1'b0, 1'b0, 3'd4, 2'b00, 9'b000101000, 8'd2};
    tbl[15] = '{16'h4000, 1'b1, 1'b0, 3'd4, 2'b00, 9'b000101000, 8'd2};
    tbl[16] = '{16'h4000, 1'b1, 1'b0, 3'd5, 2'b00, 9'b000000110, 8'd2};
    tbl[17] = '{16'h6000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd3}; // STORE
    tbl[18] = '{16'h6000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd3};
    tbl[19] = '{16'h6000, 1'b1, 1'b0, 3'd3, 2'b00, 9'b000000000, 8'd3};
    tbl[20] = '{16'h6000, 1'b1, 1'b0, 3'd4, 2'b00, 9'b000011000, 8'd3};
    tbl[21] = '{16'h8000, 1'b1, 1'b1, 3'd1, 2'b00, 9'b110100000, 8'd4}; // BEQZ taken
    tbl[22] = '{16'h8000, 1'b1, 1'b1, 3'd2, 2'b00, 9'b000000000, 8'd4};
    tbl[23] = '{16'h8000, 1'b1, 1'b1, 3'd3, 2'b00, 9'b001000000, 8'd4};
    tbl[24] = '{16'h8000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd5}; // BEQZ not taken
    tbl[25] = '{16'h8000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd5};
    tbl[26] = '{16'h8000, 1'b1, 1'b0, 3'd3, 2'b00, 9'b000000000, 8'd5};
    tbl[27] = '{16'hA000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd6}; // JUMP
    tbl[28] = '{16'hA000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b001000000, 8'd6};
    tbl[29] = '{16'hC000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd7}; // NOP
    tbl[30] = '{16'hC000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd7};
    tbl[31] = '{16'hC000, 1'b0, 1'b0, 3'd1, 2'b00, 9'b000100000, 8'd8}; // NOP, fetch stall
    tbl[32] = '{16'hC000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd8};
    tbl[33] = '{16'hC000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd8};
    tbl[34] = '{16'hE000, 1'b1, 1'b0, 3'd1, 2'b00, 9'b110100000, 8'd9}; // HALT
    tbl[35] = '{16'hE000, 1'b1, 1'b0, 3'd2, 2'b00, 9'b000000000, 8'd9};
    tbl[36] = '{16'hE000, 1'b1, 1'b0, 3'd6, 2'b00, 9'b000000001, 8'd9};

    bus.instr = 16'h0000;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_all("reset", 3'd0, 2'b00, 9'b0, 8'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NVEC; r++) begin
      if (r > 0) @(negedge clk);
      drive(tbl[r].instr, tbl[r].mem_ready, tbl[r].zero);
      chk_all($sformatf("vec%0d", r), tbl[r].exp_state, tbl[r].exp_alu,
              tbl[r].exp_ctrl, tbl[r].exp_retired);
    end

    // HALT is sticky regardless of inputs; counter frozen.
    for (int k = 0; k < 20; k++) begin
      cycle(16'($urandom), 1'($urandom), 1'($urandom));
      chk_all($sformatf("halt%0d", k), 3'd6, 2'b00, 9'b000000001, 8'd9);
    end

    // Reset out of HALT, run a NOP, then reset asynchronously mid-STORE.
    #2 rst_n = 1'b0;
    #1 chk_all("halt_rst", 3'd0, 2'b00, 9'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hC000, 1'b1, 1'b0);
    chk_all("rs_idle", 3'd0, 2'b00, 9'b0, 8'd0);
    cycle(16'hC000, 1'b1, 1'b0);
    cycle(16'hC000, 1'b1, 1'b0);
    cycle(16'h6000, 1'b1, 1'b0);
    chk_all("rs_fetch", 3'd1, 2'b00, 9'b110100000, 8'd1);
    cycle(16'h6000, 1'b1, 1'b0);
    cycle(16'h6000, 1'b1, 1'b0);
    cycle(16'h6000, 1'b0, 1'b0);
    chk_all("rs_mem", 3'd4, 2'b00, 9'b000011000, 8'd1);
    #2 rst_n = 1'b0;
    #1 chk_all("rs_async", 3'd0, 2'b00, 9'b0, 8'd0);

    // Counter wrap: 2^CNT_W NOPs bring retired back to zero.
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hC000, 1'b1, 1'b0);
    for (int n = 0; n < (1 << CNT_W); n++) begin
      cycle(16'hC000, 1'b1, 1'b0);
      chk("wrap_cnt", {{(32-CNT_W){1'b0}}, bus.retired}, 32'(n));
      cycle(16'hC000, 1'b1, 1'b0);
    end
    cycle(16'hC000, 1'b1, 1'b0);
    chk_all("wrap_zero", 3'd1, 2'b00, 9'b110100000, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle control unit for the 16-bit RISC core. Sequences each instruction through fetch/decode/execute/memory/writeback. Drives the 2-bit ALU_sel consumed by the ALU decoder (00 = add for address/compare, 01 = R-type function instr[12:9], 10 = immediate function from instr[2:0]). Also produces PC, IR, memory and register-file strobes, plus a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  16  IR contents; valid from DECODE onward; opcode = instr[15:13]
mem_ready  input  1  memory handshake; access completes in the cycle it is 1
zero  input  1  ALU zero flag, sampled in EXEC of BEQZ
ALU_sel  output  2  ALU decoder select (00/01/10; 11 never driven)
ir_load  output  1  load IR from memory data
pc_inc  output  1  PC <= PC+1
pc_load  output  1  PC <= branch/jump target
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
addr_sel  output  1  0 = PC drives address, 1 = ALU result
reg_wr  output  1  register-file write enable
wb_sel  output  1  0 = ALU result, 1 = memory data
halted  output  1  core halted
retired  output  CNT_W  instructions completed, wraps
state  output  3  current state (debug)

Behaviour:
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. 7 is unreachable; if entered, go to IDLE.
- Reset (async, rst_n=0): state=IDLE, retired=0. All control outputs are 0 immediately, including mem_rd/mem_wr mid-access.
- All control outputs are Moore/Mealy decode of the registered state, instr, mem_ready and zero. Only state and retired are registered.
- IDLE: all outputs 0; next FETCH unconditionally (one cycle after reset release).
- FETCH: mem_rd=1, addr_sel=0. Stay while mem_ready=0. When mem_ready=1: ir_load=1, pc_inc=1, next DECODE.
- DECODE, by opcode:
  - 000 R-ALU, 001 I-ALU, 010 LOAD, 011 STORE, 100 BEQZ: next EXEC.
  - 101 JUMP: pc_load=1, retire, next FETCH.
  - 110 NOP: retire, next FETCH.
  - 111 HALT: next HALT.
- EXEC, by opcode:
  - R-ALU: ALU_sel=01; next WB.
  - I-ALU: ALU_sel=10; next WB.
  - LOAD/STORE: ALU_sel=00; next MEM.
  - BEQZ: ALU_sel=00; pc_load=zero; retire; next FETCH.
- MEM: addr_sel=1; ALU_sel held at 00.
  - LOAD: mem_rd=1.
  - STORE: mem_wr=1.
  - Stay while mem_ready=0.
  - On mem_ready=1: LOAD goes to WB; STORE retires and goes to FETCH.
- WB: reg_wr=1 for one cycle; wb_sel=1 for LOAD, 0 otherwise. ALU_sel holds the EXEC value (01/10/00) so the result stays stable. Retire; next FETCH.
- HALT: halted=1, all other control outputs 0, retired frozen; exit only by reset.
- "retire" = retired increments by 1 at the clock edge ending that cycle. Exactly one increment per instruction; HALT not counted. Wraps 2^CNT_W-1 -> 0.
- Outside the active states listed above, ALU_sel=00.
- Minimum latency with mem_ready tied 1 (cycles):
  - R/I-ALU: 4 (FETCH, DECODE, EXEC, WB).
  - LOAD: 5.
  - STORE: 4.
  - BEQZ: 3.
  - JUMP/NOP: 2.
- Never assert mem_rd and mem_wr together. Never assert pc_inc and pc_load together.

Test Plan:
- Reset, release, mem_ready=1, instr=0x0200 (R-ALU) -> states 0,1,2,3,5,1; ALU_sel=01 in EXEC and WB; reg_wr=1 one cycle; wb_sel=0; retired=1.
- instr=0x2005 (I-ALU) -> ALU_sel=10 in EXEC/WB; retired increments once after 4 cycles.
- LOAD (0x4000) with mem_ready=0 for 3 cycles in MEM -> mem_rd=1, addr_sel=1 held 3 extra cycles; then WB with wb_sel=1, reg_wr=1. STORE (0x6000) -> mem_wr=1 in MEM, no reg_wr, returns to FETCH.
- BEQZ (0x8000): zero=1 -> pc_load=1 in EXEC; zero=0 -> pc_load=0. JUMP (0xA000) -> pc_load=1 in DECODE, 2-cycle instruction.
- HALT (0xE000) -> halted=1 from next cycle, outputs 0, retired frozen for 20 cycles. Assert rst_n=0 mid-MEM of a STORE -> mem_wr drops same cycle, state=IDLE, retired=0.
- Preload retired to 0xFFFF (run 65535 NOPs) then one NOP -> retired=0x0000; check mem_rd/mem_wr and pc_inc/pc_load never coincide throughout.
